// File: rtl/fft_pkg.sv
// Shared FFT widths and complex sample types.
package fft_pkg;

    localparam int FFT_IWIDTH = 16;
    localparam int FFT_OWIDTH = 17;
    localparam int FFT_LGFFT  = 12;

    typedef struct packed {
        logic signed [FFT_IWIDTH-1:0] re;
        logic signed [FFT_IWIDTH-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [FFT_OWIDTH-1:0] re;
        logic signed [FFT_OWIDTH-1:0] im;
    } cplx_out_t;

endpackage

// File: rtl/laststage_ser.sv
// Re-serialises butterfly left/right results into one valid/ready stream.
import fft_pkg::*;

module laststage_ser #(
    parameter int OWIDTH = FFT_OWIDTH
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_ready,
    input  logic                i_sof,
    input  logic [2*OWIDTH-1:0] i_left,
    input  logic [2*OWIDTH-1:0] i_right,
    output logic                o_valid,
    output logic [2*OWIDTH-1:0] o_data,
    output logic                o_sof,
    output logic                o_consume
);

    logic out_phase_q, out_phase_d;

    always_comb begin
        out_phase_d = out_phase_q;
        if (i_valid && i_ready)
            out_phase_d = !out_phase_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            out_phase_q <= 1'b0;
        else
            out_phase_q <= out_phase_d;
    end

    assign o_valid   = i_valid;
    assign o_data    = out_phase_q ? i_right : i_left;
    assign o_sof     = !out_phase_q && i_sof;
    assign o_consume = i_valid && out_phase_q && i_ready;

endmodule

// File: rtl/laststage_sched.sv
// Pairs the input stream, sequences the last-stage butterfly and
// tracks its three-enable pipeline under output backpressure.
import fft_pkg::*;

module laststage_sched #(
    parameter int IWIDTH = FFT_IWIDTH,
    parameter int OWIDTH = FFT_OWIDTH,
    parameter int LGFFT  = FFT_LGFFT
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [2*IWIDTH-1:0] i_data,
    input  logic                i_sof,
    output logic                o_bf_ce,
    output logic                o_bf_sync,
    output logic [2*IWIDTH-1:0] o_bf_left,
    output logic [2*IWIDTH-1:0] o_bf_right,
    input  logic [2*OWIDTH-1:0] i_bf_left,
    input  logic [2*OWIDTH-1:0] i_bf_right,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [2*OWIDTH-1:0] o_data,
    output logic                o_sof,
    output logic                o_err,
    output logic                o_busy
);

    localparam int CW = LGFFT - 1;

    logic          phase_q, phase_d;
    logic          synced_q, synced_d;
    logic          pair_v_q, pair_v_d;
    logic [2:0]    vld_q, vld_d;
    logic [2:0]    sof_q, sof_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [2*IWIDTH-1:0] even_q, even_d;
    logic                even_sof_q, even_sof_d;
    logic [2*IWIDTH-1:0] left_q, left_d;
    logic [2*IWIDTH-1:0] right_q, right_d;
    logic                psof_q, psof_d;

    logic consume;
    logic accept;

    assign o_bf_ce = (pair_v_q || |vld_q) && (!vld_q[2] || consume);
    assign o_ready = !synced_q || !phase_q || !pair_v_q
                   || (o_bf_ce && pair_v_q);
    assign accept  = i_valid && o_ready;

    always_comb begin
        phase_d    = phase_q;
        synced_d   = synced_q;
        pair_v_d   = pair_v_q;
        vld_d      = vld_q;
        sof_d      = sof_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        even_d     = even_q;
        even_sof_d = even_sof_q;
        left_d     = left_q;
        right_d    = right_q;
        psof_d     = psof_q;

        if (o_bf_ce) begin
            vld_d    = {vld_q[1:0], pair_v_q};
            sof_d    = {sof_q[1:0], pair_v_q && psof_q};
            pair_v_d = 1'b0;
        end

        if (accept) begin
            if (i_sof) begin
                // A misplaced sof restarts pairing on itself
                if (synced_q && (phase_q || cnt_q != '0))
                    err_d = 1'b1;
                synced_d   = 1'b1;
                cnt_d      = '0;
                even_d     = i_data;
                even_sof_d = 1'b1;
                phase_d    = 1'b1;
            end else if (synced_q) begin
                if (!phase_q) begin
                    even_d     = i_data;
                    even_sof_d = 1'b0;
                    phase_d    = 1'b1;
                end else begin
                    left_d   = even_q;
                    right_d  = i_data;
                    psof_d   = even_sof_q;
                    pair_v_d = 1'b1;
                    phase_d  = 1'b0;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q  <= 1'b0;
            synced_q <= 1'b0;
            pair_v_q <= 1'b0;
            vld_q    <= '0;
            sof_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            synced_q <= synced_d;
            pair_v_q <= pair_v_d;
            vld_q    <= vld_d;
            sof_q    <= sof_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        even_q     <= even_d;
        even_sof_q <= even_sof_d;
        left_q     <= left_d;
        right_q    <= right_d;
        psof_q     <= psof_d;
    end

    assign o_bf_left  = left_q;
    assign o_bf_right = right_q;
    assign o_bf_sync  = pair_v_q && psof_q;
    assign o_err      = err_q;
    assign o_busy     = phase_q || pair_v_q || |vld_q;

    laststage_ser #(
        .OWIDTH(OWIDTH)
    ) u_ser (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (vld_q[2]),
        .i_ready  (i_ready),
        .i_sof    (sof_q[2]),
        .i_left   (i_bf_left),
        .i_right  (i_bf_right),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_sof    (o_sof),
        .o_consume(consume)
    );

endmodule

// File: tb/tb_laststage_sched.sv
// Directed bench for laststage_sched with a 3-enable butterfly model.
module tb_laststage_sched;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        i_sof;
    logic        o_bf_ce;
    logic        o_bf_sync;
    logic [31:0] o_bf_left;
    logic [31:0] o_bf_right;
    logic [33:0] i_bf_left;
    logic [33:0] i_bf_right;
    logic        o_valid;
    logic        i_ready;
    logic [33:0] o_data;
    logic        o_sof;
    logic        o_err;
    logic        o_busy;

    int nassert = 0;
    int nfail   = 0;

    typedef struct packed {
        logic        sof;
        logic [15:0] re;
    } smp_t;

    typedef struct packed {
        logic        sof;
        logic [33:0] d;
    } exp_t;

    smp_t in_q[$];
    exp_t exp_q[$];

    int lat_idx;
    int r_t1;
    int r_tout;
    int r_err_rise;
    int r_sof_cyc;

    always #5 clk = ~clk;

    laststage_sched dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_sof     (i_sof),
        .o_bf_ce   (o_bf_ce),
        .o_bf_sync (o_bf_sync),
        .o_bf_left (o_bf_left),
        .o_bf_right(o_bf_right),
        .i_bf_left (i_bf_left),
        .i_bf_right(i_bf_right),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_sof     (o_sof),
        .o_err     (o_err),
        .o_busy    (o_busy)
    );

    function automatic logic [33:0] bfly(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input bit sub);
        logic signed [16:0] ar, ai, br, bi, r, i;
        ar = {a[31], a[31:16]};
        ai = {a[15], a[15:0]};
        br = {b[31], b[31:16]};
        bi = {b[15], b[15:0]};
        r  = sub ? ar - br : ar + br;
        i  = sub ? ai - bi : ai + bi;
        return {r, i};
    endfunction

    logic [33:0] p1l, p1r, p2l, p2r, p3l, p3r;

    always @(posedge clk) begin
        if (o_bf_ce) begin
            p1l <= bfly(o_bf_left, o_bf_right, 1'b0);
            p1r <= bfly(o_bf_left, o_bf_right, 1'b1);
            p2l <= p1l;
            p2r <= p1r;
            p3l <= p2l;
            p3r <= p2r;
        end
    end

    assign i_bf_left  = p3l;
    assign i_bf_right = p3r;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] mk(input int x);
        logic [16:0] r;
        r = x[16:0];
        return {r, 17'd0};
    endfunction

    task automatic push_in(input bit sof, input int v);
        smp_t s;
        s.sof = sof;
        s.re  = v[15:0];
        in_q.push_back(s);
    endtask

    task automatic push_pair(input bit sof, input int e, input int o);
        exp_t x;
        x.sof = sof;
        x.d   = mk(e + o);
        exp_q.push_back(x);
        x.sof = 1'b0;
        x.d   = mk(e - o);
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_ready = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready low one cycle in three
    task automatic run(input int mode, input int maxc);
        int cyc = 0;
        int in_idx = 0;
        bit stall = 1'b0;
        logic [33:0] hd;
        logic hs;
        exp_t e;
        r_t1 = -1;
        r_tout = -1;
        r_err_rise = -1;
        r_sof_cyc = -1;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < maxc) begin
            @(negedge clk);
            i_valid = in_q.size() > 0;
            if (i_valid) begin
                i_sof  = in_q[0].sof;
                i_data = {in_q[0].re, 16'd0};
            end else begin
                i_sof = 1'b0;
            end
            i_ready = (mode == 0) ? 1'b1 : (cyc % 3 != 2);
            #1;
            if (stall) begin
                chk("stall_data", o_data, hd);
                chk("stall_sof", o_sof, hs);
            end
            stall = o_valid && !i_ready;
            if (stall) begin
                hd = o_data;
                hs = o_sof;
                chk("ce_blocked", o_bf_ce, 0);
            end
            if (o_err && r_err_rise < 0)
                r_err_rise = cyc;
            if (i_valid && o_ready) begin
                if (i_sof)
                    r_sof_cyc = cyc;
                if (in_idx == lat_idx)
                    r_t1 = cyc;
                in_idx++;
                void'(in_q.pop_front());
            end
            if (o_valid && i_ready) begin
                if (r_tout < 0)
                    r_tout = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", o_data, e.d);
                    chk("out_sof", o_sof, e.sof);
                end
            end
            cyc++;
        end
        chk("timeout_left", in_q.size() + exp_q.size(), 0);
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        lat_idx = 1;
        do_reset();
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ce", o_bf_ce, 0);
        chk("rst_sync", o_bf_sync, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ready", o_ready, 1);

        // full frame, no backpressure
        for (int n = 0; n < 4096; n++)
            push_in(n == 0, n);
        for (int k = 0; k < 2048; k++)
            push_pair(k == 0, 2 * k, 2 * k + 1);
        lat_idx = 1;
        run(0, 6000);
        chk("t1_latency", r_tout - r_t1, 4);
        chk("t1_err", o_err, 0);

        // same frame with stalls
        for (int n = 0; n < 4096; n++)
            push_in(n == 0, n);
        for (int k = 0; k < 2048; k++)
            push_pair(k == 0, 2 * k, 2 * k + 1);
        run(1, 20000);
        chk("t2_err", o_err, 0);

        // samples ahead of the first sof are dropped
        do_reset();
        for (int n = 0; n < 5; n++)
            push_in(1'b0, 900 + n);
        for (int n = 0; n < 8; n++)
            push_in(n == 0, n);
        for (int k = 0; k < 4; k++)
            push_pair(k == 0, 2 * k, 2 * k + 1);
        lat_idx = 6;
        run(0, 100);
        chk("t3_latency", r_tout - r_t1, 4);
        chk("t3_err", o_err, 0);

        // three pairs then drain
        do_reset();
        for (int n = 0; n < 6; n++)
            push_in(n == 0, 10 + n);
        for (int k = 0; k < 3; k++)
            push_pair(k == 0, 10 + 2 * k, 11 + 2 * k);
        run(0, 100);
        #1;
        chk("t5_busy", o_busy, 0);
        chk("t5_valid", o_valid, 0);

        // sof on an odd position
        do_reset();
        push_in(1'b1, 0);
        push_in(1'b0, 1);
        push_in(1'b0, 2);
        push_in(1'b1, 100);
        push_in(1'b0, 101);
        push_in(1'b0, 102);
        push_in(1'b0, 103);
        push_pair(1'b1, 0, 1);
        push_pair(1'b1, 100, 101);
        push_pair(1'b0, 102, 103);
        run(0, 100);
        chk("t4_err_rise", r_err_rise, r_sof_cyc + 1);
        chk("t4_err", o_err, 1);

        // reset with two pairs in flight
        do_reset();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_ready = 1'b0;
            i_sof   = (n == 0) || (n == 2);
            i_data  = {16'(n), 16'd0};
            #1;
            chk("t6_ready", o_ready, 1);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("t6_pre_valid", o_valid, 1);
        chk("t6_pre_busy", o_busy, 1);
        chk("t6_pre_err", o_err, 1);
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_valid", o_valid, 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_err", o_err, 0);
        chk("t6_ce", o_bf_ce, 0);
        @(negedge clk);
        i_reset = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 8; n++)
            push_in(n == 0, 200 + n);
        for (int k = 0; k < 4; k++)
            push_pair(k == 0, 200 + 2 * k, 201 + 2 * k);
        run(0, 100);
        chk("t6_after_err", o_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule

// File: doc/laststage_sched.md
Name: laststage_sched

Overview:
- Sequencer and flow controller for the final radix-2 butterfly stage of the 4096-point FFT.
- Pairs a one-sample-per-clock complex input stream into even/odd (left/right) pairs.
- Drives the butterfly's clock enable and sync, tracks in-flight data across its 3-enable latency, and re-serialises each result pair to a valid/ready output stream.
- Handles backpressure and checks frame alignment.

Parameters:
- IWIDTH, 16, input component width (real or imag).
- OWIDTH, 17, butterfly output component width.
- LGFFT, 12, log2 of FFT size; a frame is 2^(LGFFT-1) pairs.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_valid  in  1  input sample valid
- o_ready  out  1  input sample accepted when i_valid and o_ready are both high
- i_data  in  2*IWIDTH  input sample {real, imag}
- i_sof  in  1  input sample is frame sample 0
- o_bf_ce  out  1  butterfly clock enable
- o_bf_sync  out  1  butterfly i_sync
- o_bf_left  out  2*IWIDTH  butterfly i_left (even sample)
- o_bf_right  out  2*IWIDTH  butterfly i_right (odd sample)
- i_bf_left  in  2*OWIDTH  butterfly o_left (sum)
- i_bf_right  in  2*OWIDTH  butterfly o_right (difference)
- o_valid  out  1  output sample valid
- i_ready  in  1  downstream ready
- o_data  out  2*OWIDTH  output sample
- o_sof  out  1  output sample is frame sample 0
- o_err  out  1  sticky frame-alignment error
- o_busy  out  1  any sample held or in flight

Behaviour:
- Reset values:
  - phase=0, synced=0, pair_v=0, vld[2:0]=0, out_phase=0, pair count=0, o_err=0.
  - Outputs at reset: o_valid=0, o_bf_ce=0, o_bf_sync=0, o_busy=0.
  - Data registers are not reset.
  - Reset mid-operation discards all held and in-flight samples; the butterfly's own sync pipeline is flushed by the shared i_reset.
- Input acceptance:
  - Before the first i_sof, accepted samples are discarded (o_ready=1).
  - An accepted sample with i_sof sets synced=1.
  - phase=0: the accepted sample goes to the even register, phase<=1.
  - phase=1: the accepted sample is the odd sample; {even, odd, sof_of_even} load the pair register, pair_v<=1, phase<=0, pair count increments mod 2^(LGFFT-1).
  - o_ready = !synced || phase==0 || !pair_v || (o_bf_ce && pair_v). This is combinational from i_ready via o_bf_ce.
- Alignment check, applied when i_sof is accepted and synced=1:
  - phase==1: set o_err, discard the held even sample, store the new sample as even, keep phase=1, count<=0.
  - phase==0 and count!=0: set o_err, count<=0, continue normally.
  - o_err clears only on reset.
- Butterfly sequencing:
  - vld[k] means butterfly pipeline stage k+1 holds a real pair; i_bf_* valid iff vld[2].
  - consume = o_valid && out_phase==1 && i_ready.
  - o_bf_ce = (pair_v || |vld) && (!vld[2] || consume).
  - On o_bf_ce: vld <= {vld[1], vld[0], pair_v}; the pair is issued if pair_v, and pair_v clears unless reloaded the same cycle.
  - Bubbles (ce with pair_v=0) drain the pipeline.
  - o_bf_left/o_bf_right/o_bf_sync are driven from the pair register; o_bf_sync=0 when pair_v=0.
- Sync tracking: a 3-bit sof shift register advances alongside vld on o_bf_ce.
- Output serialiser:
  - o_valid = vld[2].
  - out_phase=0 → o_data=i_bf_left, o_sof=sof[2].
  - out_phase=1 → o_data=i_bf_right, o_sof=0.
  - out_phase toggles on each o_valid&&i_ready handshake.
  - o_data/o_sof are stable while o_valid && !i_ready.
- Latency (unloaded, i_ready=1): odd-sample handshake in cycle 0 → left output in cycle 4, right in cycle 5.
- Throughput: sustained 1 sample/clock in and out.
- o_busy = phase || pair_v || |vld.

Decomposition:
- fft_pkg holds IWIDTH, OWIDTH, LGFFT defaults, and the cplx_in_t/cplx_out_t packed {re, im} typedefs.
- One sub-module: laststage_ser (out_phase register plus left/right mux with consume generation).
- The butterfly is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then i_sof+4096 continuous samples (x[n]=n real, 0 imag), i_ready=1 → 4096 outputs: pairs (2k+(2k+1), -1) with o_sof only on the first. First left output appears 4 cycles after sample 1's handshake. No o_bf_ce gaps beyond bubbles, o_err=0.
- Same stream with i_ready toggling 1-of-3 → identical output sequence, no loss or duplication; o_bf_ce low whenever vld[2] and not consumed; o_data stable while stalled.
- 5 samples before the first i_sof → all 5 discarded; outputs begin with the pair formed from the sof sample.
- i_sof on an odd position mid-frame → o_err=1 next cycle; the held even sample is dropped; the new sof sample becomes left of the next pair and its output carries o_sof.
- Input stops after 3 pairs, i_ready=1 → pipeline drains via bubbles, 6 outputs, o_busy falls to 0 after the last handshake.
- i_reset asserted with 2 pairs in flight → next cycle o_valid=0, o_busy=0, o_err=0; a new frame afterwards produces correct results.
